game_event_reporter: RTL and testbench
======================================

Name: game_event_reporter

Overview:
Collects gameplay events raised by the game logic (alien hit by missile, ship hit, missile fired). Timestamps each event with a frame counter and buffers it in a FIFO. Presents events one at a time to the NIOS II over a PIO-style 4-phase valid/ack handshake. This is the FPGA-to-software direction, complementing the software-to-FPGA keycode, hex and LED PIOs. It sits beside the missile and collision logic in the top level, clocked by MAX10_CLK1_50.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
STAMP_W, 10, frame stamp width; fixed at 10 for the 16-bit event word

Ports:
Clk  in  1  system clock, MAX10_CLK1_50
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  VGA vertical sync; a rising edge marks a new frame
alien_hit  in  1  single-cycle pulse, missile hit an alien
alien_idx  in  4  alien index 0-14, valid with alien_hit
ship_hit  in  1  single-cycle pulse
missile_fire  in  1  single-cycle pulse
evt_data  out  16  event word: [15:14] type (01 alien hit, 10 ship hit, 11 missile fire, 00 unused); [13:10] index (alien_idx, 0 for other types); [9:0] frame stamp
evt_valid  out  1  evt_data is valid for software
evt_ack  in  1  software acknowledge, a level driven through PIO
fifo_count  out  $clog2(DEPTH)+1  entries currently stored
drop_count  out  8  saturating count of lost events
frame_count  out  10  current frame stamp

Behaviour:
- Reset values:
  - All outputs 0.
  - Pending flags clear, FIFO empty.
  - Handshake state = WAIT_LOW, so ack must be seen low before the first presentation.
- Frame stamp:
  - frame_clk is registered once and compared with its previous value.
  - A 0->1 transition increments frame_count, wrapping 1023->0.
  - An event captures the frame_count register value in its pulse cycle (the pre-increment value).
- Capture:
  - One pending slot per source holds a flag, a stamp and (alien only) an index.
  - A pulse sets the slot.
  - A pulse to an already-pending slot that is not being cleared that cycle is dropped: the slot keeps its first contents and drop_count increments.
  - A pulse in the same cycle the slot is cleared refills the slot and is not dropped.
- Arbitration:
  - Each cycle, if any slot is pending and the FIFO is not full, one slot is pushed and cleared.
  - Fixed priority: alien_hit > ship_hit > missile_fire.
  - When the FIFO is full, slots stay pending (backpressure); loss happens only through the slot-collision drop above.
- FIFO:
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop only when fifo_count > 0.
- Handshake FSM:
  - IDLE: if fifo_count > 0, load the head into evt_data, pop, set evt_valid=1, go to PRESENT.
  - PRESENT: on evt_ack=1, clear evt_valid and go to WAIT_LOW.
  - WAIT_LOW: on evt_ack=0, go to IDLE.
  - evt_data holds its value after evt_valid drops, until the next load.
- Latency:
  - Pulse in cycle t → slot set at edge t+1 → FIFO push at edge t+2 → evt_valid=1 after edge t+3 (FIFO empty, state IDLE).
  - evt_valid falls on the first edge where evt_ack=1 is sampled in PRESENT.
- drop_count saturates at 255 and is cleared only by Reset.
- Reset mid-handshake clears everything. evt_valid stays 0 until evt_ack has been sampled low.

Decomposition:
- Package game_event_pkg:
  - evt_type_t enum (EVT_NONE=00, EVT_ALIEN=01, EVT_SHIP=10, EVT_FIRE=11)
  - field position constants (TYPE_MSB/LSB, IDX_MSB/LSB, STAMP_MSB/LSB)
  - hs_state_t enum (IDLE, PRESENT, WAIT_LOW)
  - EVT_W=16
- Sub-module event_fifo (parameters DEPTH, WIDTH; ports push, push_data, pop, head_data, count, full, empty).
  - Synchronous FIFO with registered pointers and a head that shows the entry at the read pointer.
- The top holds the frame counter, pending slots, arbiter and handshake FSM.

Test Plan:
- After reset, hold evt_ack=0; pulse alien_hit with alien_idx=7 at frame_count=0 → evt_valid=1 three edges later with evt_data=0x5C00; evt_ack=1 → evt_valid=0 next edge; evt_ack=0 → return to IDLE.
- At frame_count=5, pulse alien_hit (idx 3), ship_hit and missile_fire in the same cycle → three handshakes in order with evt_data 0x4C05, 0x8005, 0xC005; drop_count=0.
- Drive 1024 frame_clk rising edges → frame_count=0; event word stamp=0; one more edge → frame_count=1.
- Hold evt_ack=0 after the first presentation; pulse missile_fire 20 times spaced 4 cycles, DEPTH=16 → 1 presented, fifo_count=16, 1 pending, drop_count=2. Then run 17 ack cycles → all 17 remaining words delivered in pulse order, fifo_count=0.
- Assert Reset while in PRESENT with evt_ack=1 and 3 entries stored → after reset all outputs are 0. Pulse ship_hit with evt_ack still 1 → evt_valid stays 0 until evt_ack=0 is sampled, then rises.
- Keep the FIFO full and a slot pending; pulse that source 300 times → drop_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/game_event_pkg.sv
//============================================================================
// Module      : game_event_pkg
// Description : Shared event-word layout, type codes and handshake states.
// Revision    : 1.0
//============================================================================
`default_nettype none

package game_event_pkg;

   localparam int EVT_W     = 16;
   localparam int TYPE_MSB  = 15;
   localparam int TYPE_LSB  = 14;
   localparam int IDX_MSB   = 13;
   localparam int IDX_LSB   = 10;
   localparam int STAMP_MSB = 9;
   localparam int STAMP_LSB = 0;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'b00,
      EVT_ALIEN = 2'b01,
      EVT_SHIP  = 2'b10,
      EVT_FIRE  = 2'b11
   } evt_type_t;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      PRESENT  = 2'b01,
      WAIT_LOW = 2'b10
   } hs_state_t;

   function automatic logic [EVT_W-1:0] pack_evt(
      input evt_type_t                    etype,
      input logic [IDX_MSB-IDX_LSB:0]     idx,
      input logic [STAMP_MSB-STAMP_LSB:0] stamp
   );
      return {etype, idx, stamp};
   endfunction

endpackage

`default_nettype wire

// File: rtl/event_fifo.sv
//============================================================================
// Module      : event_fifo
// Description : Synchronous FIFO; head_data always shows the oldest entry.
// Revision    : 1.0
//============================================================================
`default_nettype none

module event_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int                c_aw   = $clog2(DEPTH);
   localparam logic [c_aw:0]     c_full = (c_aw+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == c_full);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head_data = r_mem[r_rd_ptr];
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/game_event_reporter.sv
//============================================================================
// Module      : game_event_reporter
// Description : Frame-stamped gameplay event capture, FIFO and valid/ack PIO.
// Revision    : 1.0
//============================================================================
`default_nettype none

module game_event_reporter
   import game_event_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int STAMP_W = 10
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_clk,
   input  logic                   alien_hit,
   input  logic [3:0]             alien_idx,
   input  logic                   ship_hit,
   input  logic                   missile_fire,
   output logic [EVT_W-1:0]       evt_data,
   output logic                   evt_valid,
   input  logic                   evt_ack,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [7:0]             drop_count,
   output logic [STAMP_W-1:0]     frame_count
);

   logic               r_fclk_d1, r_fclk_d2;
   logic [STAMP_W-1:0] r_frame_count;
   logic               r_alien_pend, r_ship_pend, r_fire_pend;
   logic [STAMP_W-1:0] r_alien_stamp, r_ship_stamp, r_fire_stamp;
   logic [3:0]         r_alien_idx;
   logic [7:0]         r_drop_count;
   logic [EVT_W-1:0]   r_evt_data;
   logic               r_evt_valid;
   hs_state_t          r_state, w_state_next;

   logic               w_push, w_full, w_empty, w_load;
   logic [EVT_W-1:0]   w_push_data, w_head;
   logic               w_clr_alien, w_clr_ship, w_clr_fire;
   logic               w_drop_alien, w_drop_ship, w_drop_fire;
   logic [1:0]         w_drop_n;
   logic [8:0]         w_drop_sum;

   assign w_push      = (r_alien_pend | r_ship_pend | r_fire_pend) & ~w_full;
   assign w_clr_alien = w_push & r_alien_pend;
   assign w_clr_ship  = w_push & ~r_alien_pend & r_ship_pend;
   assign w_clr_fire  = w_push & ~r_alien_pend & ~r_ship_pend & r_fire_pend;

   // A pulse only collides when its slot is full and not draining this cycle.
   assign w_drop_alien = alien_hit    & r_alien_pend & ~w_clr_alien;
   assign w_drop_ship  = ship_hit     & r_ship_pend  & ~w_clr_ship;
   assign w_drop_fire  = missile_fire & r_fire_pend  & ~w_clr_fire;
   assign w_drop_n     = {1'b0, w_drop_alien} + {1'b0, w_drop_ship} + {1'b0, w_drop_fire};
   assign w_drop_sum   = {1'b0, r_drop_count} + {7'b0, w_drop_n};

   always_comb begin
      w_push_data = pack_evt(EVT_NONE, 4'd0, 10'd0);
      if (r_alien_pend)     w_push_data = pack_evt(EVT_ALIEN, r_alien_idx, r_alien_stamp);
      else if (r_ship_pend) w_push_data = pack_evt(EVT_SHIP, 4'd0, r_ship_stamp);
      else if (r_fire_pend) w_push_data = pack_evt(EVT_FIRE, 4'd0, r_fire_stamp);
   end

   event_fifo #(.DEPTH(DEPTH), .WIDTH(EVT_W)) u_fifo (
      .clk       (Clk),
      .rst       (Reset),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_load),
      .head_data (w_head),
      .count     (fifo_count),
      .full      (w_full),
      .empty     (w_empty)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_fclk_d1     <= 1'b0;
         r_fclk_d2     <= 1'b0;
         r_frame_count <= '0;
         r_alien_pend  <= 1'b0;
         r_ship_pend   <= 1'b0;
         r_fire_pend   <= 1'b0;
         r_alien_stamp <= '0;
         r_ship_stamp  <= '0;
         r_fire_stamp  <= '0;
         r_alien_idx   <= '0;
         r_drop_count  <= '0;
      end else begin
         r_fclk_d1 <= frame_clk;
         r_fclk_d2 <= r_fclk_d1;
         if (r_fclk_d1 & ~r_fclk_d2) r_frame_count <= r_frame_count + 1'b1;

         if (alien_hit && !w_drop_alien) begin
            r_alien_pend  <= 1'b1;
            r_alien_stamp <= r_frame_count;
            r_alien_idx   <= alien_idx;
         end else if (w_clr_alien) r_alien_pend <= 1'b0;

         if (ship_hit && !w_drop_ship) begin
            r_ship_pend  <= 1'b1;
            r_ship_stamp <= r_frame_count;
         end else if (w_clr_ship) r_ship_pend <= 1'b0;

         if (missile_fire && !w_drop_fire) begin
            r_fire_pend  <= 1'b1;
            r_fire_stamp <= r_frame_count;
         end else if (w_clr_fire) r_fire_pend <= 1'b0;

         r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         IDLE: if (!w_empty) begin
            w_load       = 1'b1;
            w_state_next = PRESENT;
         end
         PRESENT:  if (evt_ack)  w_state_next = WAIT_LOW;
         WAIT_LOW: if (!evt_ack) w_state_next = IDLE;
         default:  w_state_next = WAIT_LOW;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= WAIT_LOW;
         r_evt_valid <= 1'b0;
         r_evt_data  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            r_evt_data  <= w_head;
            r_evt_valid <= 1'b1;
         end else if (r_state == PRESENT && evt_ack) begin
            r_evt_valid <= 1'b0;
         end
      end
   end

   assign evt_data    = r_evt_data;
   assign evt_valid   = r_evt_valid;
   assign drop_count  = r_drop_count;
   assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_game_event_reporter.sv
//============================================================================
// Module      : tb_game_event_reporter
// Description : Directed stimulus with a queue scoreboard for game_event_reporter.
// Revision    : 1.0
//============================================================================
`default_nettype none

module tb_game_event_reporter;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic        alien_hit = 1'b0;
   logic [3:0]  alien_idx = 4'd0;
   logic        ship_hit = 1'b0;
   logic        missile_fire = 1'b0;
   logic        evt_ack = 1'b0;
   logic [15:0] evt_data;
   logic        evt_valid;
   logic [4:0]  fifo_count;
   logic [7:0]  drop_count;
   logic [9:0]  frame_count;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] exp_q[$];
   logic        prev_valid = 1'b0;

   game_event_reporter #(.DEPTH(16), .STAMP_W(10)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .alien_hit    (alien_hit),
      .alien_idx    (alien_idx),
      .ship_hit     (ship_hit),
      .missile_fire (missile_fire),
      .evt_data     (evt_data),
      .evt_valid    (evt_valid),
      .evt_ack      (evt_ack),
      .fifo_count   (fifo_count),
      .drop_count   (drop_count),
      .frame_count  (frame_count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitor: every new presentation is compared with the oldest expectation.
   always @(negedge Clk) begin
      if (evt_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL evt_unexpected: got 0x%0h, required no event", evt_data);
         end else begin
            check("evt_data", {16'd0, evt_data}, {16'd0, exp_q.pop_front()});
         end
      end
      prev_valid = evt_valid;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge Clk);
   endtask

   task automatic pulse_fire();
      missile_fire = 1'b1;
      tick();
      missile_fire = 1'b0;
   endtask

   task automatic frame_edge();
      frame_clk = 1'b1;
      tick(2);
      frame_clk = 1'b0;
      tick(2);
   endtask

   task automatic do_ack(input string name);
      int k = 0;
      while (!evt_valid && k < 60) begin
         tick();
         k++;
      end
      if (!evt_valid) begin
         n_checks++;
         $display("FAIL %s_timeout: evt_valid=0, required 1", name);
         return;
      end
      evt_ack = 1'b1;
      tick();
      check({name, "_fall"}, {31'd0, evt_valid}, 32'd0);
      evt_ack = 1'b0;
      tick(2);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
      check({tag, "_data"},  {16'd0, evt_data},  32'd0);
      check({tag, "_count"}, {27'd0, fifo_count}, 32'd0);
      check({tag, "_drop"},  {24'd0, drop_count}, 32'd0);
      check({tag, "_frame"}, {22'd0, frame_count}, 32'd0);
   endtask

   initial begin
      logic seen;
      tick(3);
      Reset = 1'b0;
      tick(3);
      check_zero("reset");

      // Latency: alien idx 7 at frame 0
      alien_hit = 1'b1; alien_idx = 4'd7;
      exp_q.push_back(16'h5C00);
      tick();
      alien_hit = 1'b0; alien_idx = 4'd0;
      check("lat_t1", {31'd0, evt_valid}, 32'd0);
      tick();
      check("lat_t2", {31'd0, evt_valid}, 32'd0);
      tick();
      check("lat_t3", {31'd0, evt_valid}, 32'd1);
      do_ack("first");

      // Simultaneous sources at frame 5
      repeat (5) frame_edge();
      check("frame5", {22'd0, frame_count}, 32'd5);
      alien_hit = 1'b1; alien_idx = 4'd3; ship_hit = 1'b1; missile_fire = 1'b1;
      exp_q.push_back(16'h4C05);
      exp_q.push_back(16'h8005);
      exp_q.push_back(16'hC005);
      tick();
      alien_hit = 1'b0; alien_idx = 4'd0; ship_hit = 1'b0; missile_fire = 1'b0;
      repeat (3) do_ack("prio");
      check("prio_drop", {24'd0, drop_count}, 32'd0);

      // Frame counter wrap
      repeat (1019) frame_edge();
      check("frame_wrap", {22'd0, frame_count}, 32'd0);
      exp_q.push_back(16'hC000);
      pulse_fire();
      do_ack("wrap_evt");
      frame_edge();
      check("frame_after_wrap", {22'd0, frame_count}, 32'd1);

      // Backpressure with ack held low
      for (int i = 0; i < 20; i++) begin
         if (i < 18) exp_q.push_back(16'hC001);
         pulse_fire();
         tick(3);
      end
      tick(5);
      check("bp_count", {27'd0, fifo_count}, 32'd16);
      check("bp_drop", {24'd0, drop_count}, 32'd2);
      check("bp_valid", {31'd0, evt_valid}, 32'd1);
      repeat (18) do_ack("bp");
      check("bp_drained", {27'd0, fifo_count}, 32'd0);

      // Reset in PRESENT with ack high and three entries stored
      exp_q.push_back(16'hC001);
      for (int i = 0; i < 4; i++) begin
         pulse_fire();
         tick(3);
      end
      check("rst_pre_count", {27'd0, fifo_count}, 32'd3);
      evt_ack = 1'b1;
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
      tick();
      check_zero("midrst");
      exp_q.push_back(16'h8000);
      ship_hit = 1'b1;
      tick();
      ship_hit = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (evt_valid) seen = 1'b1;
         tick();
      end
      check("ack_high_holds", {31'd0, seen}, 32'd0);
      evt_ack = 1'b0;
      do_ack("post_rst");

      // Drop counter saturation
      for (int i = 0; i < 18; i++) begin
         exp_q.push_back(16'hC000);
         pulse_fire();
         tick(3);
      end
      repeat (300) pulse_fire();
      tick(3);
      check("sat_count", {27'd0, fifo_count}, 32'd16);
      check("sat_drop", {24'd0, drop_count}, 32'd255);
      repeat (18) do_ack("sat");
      check("sat_drop_held", {24'd0, drop_count}, 32'd255);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
